hazard_sched: RTL and testbench

- Pipeline hazard scheduler for the 5-stage MIPS core.
- Tracks in-flight register writers in E/M/W in its own shift pipeline. Decides D-stage stall and bubble insertion.
- Produces forwarding selects for D-stage consumers (branch/jr/ji compare) and E-stage consumers (ALU/store operands). The select encoding matches the existing bypass muxes.
- Also sequences the multi-cycle mult/div unit busy window (optional feature).

---
 rtl/hazard_sched.sv | 161 ++++++++++++++++
 tb/tb_hazard_sched.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_sched.sv
// rtl/hazard_sched.sv - D-stage stall and bypass select generation for the 5-stage MIPS pipeline.
// Optional HI/LO busy sequencing is built when HAZARD_MDU_EN is defined.
module hazard_sched #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d_valid,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_rs_tuse,
  input  logic [1:0] d_rt_tuse,
  input  logic [4:0] d_dst,
  input  logic [1:0] d_tnew,
  input  logic       d_mdu_start,
  input  logic       d_mdu_div,
  input  logic       d_mdu_read,
  output logic       stall,
  output logic [1:0] fwd_rs_D,
  output logic [1:0] fwd_rt_D,
  output logic [1:0] fwd_rs_E,
  output logic [1:0] fwd_rt_E,
  output logic       mdu_busy
);

  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
  } entry_t;

  entry_t e_q, e_d, m_q, m_d, w_q, w_d;
  logic   stall_reg;
  logic   stall_mdu;
  logic   issue;

  function automatic logic [1:0] age(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Newest in-flight writer of r: 1=E, 2=M, 3=W, 0=none. Register 0 never matches.
  function automatic logic [1:0] newest(input logic [4:0] r, input entry_t e,
                                        input entry_t m, input entry_t w);
    logic [1:0] idx;
    idx = 2'd0;
    if (r != 5'd0) begin
      if (r == e.dst)      idx = 2'd1;
      else if (r == m.dst) idx = 2'd2;
      else if (r == w.dst) idx = 2'd3;
    end
    return idx;
  endfunction

  function automatic logic [1:0] sel_tnew(input logic [1:0] idx, input entry_t e,
                                          input entry_t m, input entry_t w);
    logic [1:0] t;
    case (idx)
      2'd1:    t = e.tnew;
      2'd2:    t = m.tnew;
      2'd3:    t = w.tnew;
      default: t = 2'd0;
    endcase
    return t;
  endfunction

  function automatic logic d_hazard(input logic [4:0] r, input logic [1:0] tuse,
                                    input entry_t e, input entry_t m, input entry_t w);
    logic [1:0] idx;
    idx = newest(r, e, m, w);
    return (idx != 2'd0) && (tuse != 2'd3) && (sel_tnew(idx, e, m, w) > tuse);
  endfunction

  function automatic logic [1:0] d_fwd(input logic [4:0] r, input entry_t e,
                                       input entry_t m, input entry_t w);
    logic [1:0] idx;
    idx = newest(r, e, m, w);
    return ((idx != 2'd0) && (sel_tnew(idx, e, m, w) == 2'd0)) ? idx : 2'd0;
  endfunction

  // E consumers only ever see M or W producers; an E-stage producer is one cycle behind.
  function automatic logic [1:0] e_fwd(input logic [4:0] r, input entry_t m, input entry_t w);
    logic [1:0] sel;
    sel = 2'd0;
    if (r != 5'd0) begin
      if ((r == m.dst) && (m.tnew == 2'd0)) sel = 2'd2;
      else if (r == w.dst)                  sel = 2'd3;
    end
    return sel;
  endfunction

  assign stall_reg = d_valid & (d_hazard(d_rs, d_rs_tuse, e_q, m_q, w_q) |
                                d_hazard(d_rt, d_rt_tuse, e_q, m_q, w_q));
  assign stall     = stall_reg | stall_mdu;
  assign issue     = d_valid & ~stall;

  assign fwd_rs_D = d_fwd(d_rs, e_q, m_q, w_q);
  assign fwd_rt_D = d_fwd(d_rt, e_q, m_q, w_q);
  assign fwd_rs_E = e_fwd(e_q.rs, m_q, w_q);
  assign fwd_rt_E = e_fwd(e_q.rt, m_q, w_q);

  always_comb begin
    e_d = '0;
    if (issue) begin
      e_d.dst  = d_dst;
      e_d.tnew = d_tnew;
      e_d.rs   = d_rs;
      e_d.rt   = d_rt;
    end
    m_d      = e_q;
    m_d.tnew = age(e_q.tnew);
    w_d      = m_q;
    w_d.tnew = age(m_q.tnew);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  logic unused_w;
  assign unused_w = ^{w_q.rs, w_q.rt};

`ifdef HAZARD_MDU_EN
  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

  logic [3:0] mdu_cnt_q, mdu_cnt_d;

  // A start blocked by a register stall must not load the counter, hence issue.
  always_comb begin
    mdu_cnt_d = mdu_cnt_q;
    if (issue && d_mdu_start)
      mdu_cnt_d = d_mdu_div ? DIV_CNT : MULT_CNT;
    else if (mdu_cnt_q != 4'd0)
      mdu_cnt_d = mdu_cnt_q - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mdu_cnt_q <= 4'd0;
    else        mdu_cnt_q <= mdu_cnt_d;
  end

  assign mdu_busy  = (mdu_cnt_q != 4'd0);
  assign stall_mdu = d_valid & (d_mdu_start | d_mdu_read) & mdu_busy;
`else
  logic unused_mdu;
  assign unused_mdu = ^{d_mdu_start, d_mdu_div, d_mdu_read, MULT_LAT[0], DIV_LAT[0]};
  assign mdu_busy   = 1'b0;
  assign stall_mdu  = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// tb/tb_hazard_sched.sv - directed vector bench for hazard_sched.
module tb_hazard_sched;

`ifdef HAZARD_MDU_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew;
  logic       d_mdu_start, d_mdu_div, d_mdu_read;
  logic       stall, mdu_busy;
  logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_sched #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse), .d_dst(d_dst), .d_tnew(d_tnew),
    .d_mdu_start(d_mdu_start), .d_mdu_div(d_mdu_div), .d_mdu_read(d_mdu_read),
    .stall(stall), .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
    .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E), .mdu_busy(mdu_busy)
  );

  typedef struct {
    logic       valid;
    logic [4:0] rs, rt;
    logic [1:0] rsu, rtu;
    logic [4:0] dst;
    logic [1:0] tnew;
    logic       x_stall;
    logic [1:0] x_rsD, x_rtD, x_rsE, x_rtE;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [1:0] rsu, input logic [1:0] rtu,
                              input logic [4:0] dst, input logic [1:0] tnew,
                              input logic xs, input logic [1:0] xrsd, input logic [1:0] xrtd,
                              input logic [1:0] xrse, input logic [1:0] xrte);
    vec_t r;
    r.valid = v; r.rs = rs; r.rt = rt; r.rsu = rsu; r.rtu = rtu; r.dst = dst; r.tnew = tnew;
    r.x_stall = xs; r.x_rsD = xrsd; r.x_rtD = xrtd; r.x_rsE = xrse; r.x_rtE = xrte;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic xs, input logic [1:0] xrsd,
                           input logic [1:0] xrtd, input logic [1:0] xrse,
                           input logic [1:0] xrte, input logic xbusy);
    chk({tag, " stall"}, int'(stall), int'(xs));
    chk({tag, " fwd_rs_D"}, int'(fwd_rs_D), int'(xrsd));
    chk({tag, " fwd_rt_D"}, int'(fwd_rt_D), int'(xrtd));
    chk({tag, " fwd_rs_E"}, int'(fwd_rs_E), int'(xrse));
    chk({tag, " fwd_rt_E"}, int'(fwd_rt_E), int'(xrte));
    chk({tag, " mdu_busy"}, int'(mdu_busy), int'(xbusy));
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] rsu, input logic [1:0] rtu, input logic [4:0] dst,
                       input logic [1:0] tnew, input logic st, input logic dv, input logic rd);
    @(negedge clk);
    d_valid = v; d_rs = rs; d_rt = rt; d_rs_tuse = rsu; d_rt_tuse = rtu;
    d_dst = dst; d_tnew = tnew; d_mdu_start = st; d_mdu_div = dv; d_mdu_read = rd;
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // v rs rt rsu rtu dst tnew | stall rsD rtD rsE rtE
    tbl[0]  = mk(1, 29, 0, 1, 3,  8, 2, 0, 0, 0, 0, 0); // lw $8
    tbl[1]  = mk(1,  8, 8, 1, 1,  9, 1, 1, 0, 0, 0, 0); // add $9,$8,$8 stalls
    tbl[2]  = mk(1,  8, 8, 1, 1,  9, 1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0,  0, 0, 3, 3,  0, 0, 0, 0, 0, 3, 3); // add in E, lw in W
    tbl[4]  = mk(0,  0, 0, 3, 3,  0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0,  0, 0, 3, 3,  0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 29, 0, 1, 3,  8, 2, 0, 0, 0, 0, 0); // lw $8
    tbl[7]  = mk(1,  8, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0); // beq $8,$0
    tbl[8]  = mk(1,  8, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0);
    tbl[9]  = mk(1,  8, 0, 0, 0,  0, 0, 0, 3, 0, 0, 0);
    tbl[10] = mk(1,  0, 0, 3, 3, 31, 0, 0, 0, 0, 0, 0); // jal
    tbl[11] = mk(1, 31, 0, 0, 3,  0, 0, 0, 1, 0, 0, 0); // jr $31
    tbl[12] = mk(1,  1, 2, 1, 1,  0, 1, 0, 0, 0, 2, 0); // add $0, jr in E sees jal in M
    tbl[13] = mk(1,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0); // beq $0,$0
    tbl[14] = mk(1,  1, 2, 1, 1,  5, 1, 0, 0, 0, 0, 0); // add $5
    tbl[15] = mk(1,  3, 0, 1, 3,  5, 1, 0, 0, 0, 0, 0); // addi $5
    tbl[16] = mk(1,  5, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0); // beq $5 shadowed by addi
    tbl[17] = mk(1,  5, 0, 0, 0,  0, 0, 0, 2, 0, 0, 0);
    tbl[18] = mk(0,  0, 0, 3, 3,  0, 0, 0, 0, 0, 3, 0);

    rst_n = 1'b0;
    d_valid = 1'b1; d_rs = 5'd8; d_rt = 5'd8; d_rs_tuse = 2'd0; d_rt_tuse = 2'd0;
    d_dst = 5'd8; d_tnew = 2'd2; d_mdu_start = 1'b1; d_mdu_div = 1'b1; d_mdu_read = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_out("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].valid, tbl[i].rs, tbl[i].rt, tbl[i].rsu, tbl[i].rtu, tbl[i].dst,
            tbl[i].tnew, 1'b0, 1'b0, 1'b0);
      check_out($sformatf("vec%0d", i), tbl[i].x_stall, tbl[i].x_rsD, tbl[i].x_rtD,
                tbl[i].x_rsE, tbl[i].x_rtE, 1'b0);
    end
    repeat (3) nop();

    // div then mflo: mflo held for DIV_LAT cycles
    drive(1, 0, 0, 3, 3, 0, 0, 1, 1, 0);
    check_out("div", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i <= 10; i++) begin
      drive(1, 0, 0, 3, 3, 2, 1, 0, 0, 1);
      chk($sformatf("mflo%0d stall", i), int'(stall), int'(MDU && (i < 10)));
      chk($sformatf("mflo%0d busy", i), int'(mdu_busy), int'(MDU && (i < 10)));
    end
    // back-to-back mult: second start stalled through counter==1
    drive(1, 0, 0, 3, 3, 0, 0, 1, 0, 0);
    chk("mult0 stall", int'(stall), 0);
    for (int j = 0; j <= 5; j++) begin
      drive(1, 0, 0, 3, 3, 0, 0, 1, 0, 0);
      chk($sformatf("mult1_%0d stall", j), int'(stall), int'(MDU && (j < 5)));
      chk($sformatf("mult1_%0d busy", j), int'(mdu_busy), int'(MDU && (j < 5)));
    end
    nop();
    chk("mult1 loaded", int'(mdu_busy), int'(MDU));
    for (int k = 1; k <= 5; k++) nop();
    chk("mdu drained", int'(mdu_busy), 0);

    // register stall on a mult start must not load the counter
    drive(1, 29, 0, 1, 3, 8, 2, 0, 0, 0);
    chk("lw before mult", int'(stall), 0);
    drive(1, 8, 0, 1, 3, 0, 0, 1, 0, 0);
    chk("mult reg stall", int'(stall), 1);
    chk("mult reg stall busy", int'(mdu_busy), 0);
    drive(1, 8, 0, 1, 3, 0, 0, 1, 0, 0);
    chk("mult retry stall", int'(stall), 0);
    chk("mult retry busy", int'(mdu_busy), 0);
    nop();
    chk("mult retry loaded", int'(mdu_busy), int'(MDU));
    repeat (6) nop();

    // asynchronous reset while jal in E forwards to jr
    drive(1, 0, 0, 3, 3, 31, 0, 0, 0, 0);
    drive(1, 31, 0, 0, 3, 0, 0, 0, 0, 0);
    chk("jr pre-reset fwd", int'(fwd_rs_D), 1);
    rst_n = 1'b0;
    #1;
    chk("jr reset fwd", int'(fwd_rs_D), 0);
    chk("jr reset stall", int'(stall), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // asynchronous reset while a load in E stalls its consumer
    drive(1, 29, 0, 1, 3, 8, 2, 1, 0, 0);
    drive(1, 8, 8, 1, 1, 9, 1, 0, 0, 0);
    chk("lw pre-reset stall", int'(stall), 1);
    chk("lw pre-reset busy", int'(mdu_busy), int'(MDU));
    rst_n = 1'b0;
    #1;
    check_out("lw reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_out("post reset", 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
